segment_pipe_reg: RTL and testbench
===================================

Name: segment_pipe_reg

Overview:
- Parametrised pipeline segment register for the vector processor pipeline. Successor to the fixed-width, always-advancing inter-stage registers.
- Carries a control bundle, a multi-lane data bundle and a destination register index between two stages.
- Adds a valid/ready handshake with a 2-entry skid buffer (stall without a combinational ready path), synchronous flush, and bubble insertion.
- Sits between any two stages, e.g. ID->EX or EX->MEM.

Parameters:
- CTRL_W, 14, width of the control bundle (jump/mem/ALU select bits, write enables).
- DATA_W, 192, width of one data lane (one vector register / PC / immediate).
- LANES, 8, number of data lanes carried in parallel.
- DEST_W, 4, destination register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  LANES*DATA_W  upstream data; lane k occupies bits [k*DATA_W +: DATA_W].
- in_dest  in  DEST_W  upstream destination index.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts the entry.
- out_ctrl  out  CTRL_W  control bundle; all zero when out_valid=0.
- out_data  out  LANES*DATA_W  data of the head entry.
- out_dest  out  DEST_W  destination index of the head entry.

Behaviour:
- Storage: head entry (drives outputs) and skid entry, each {valid, ctrl, data, dest}.
- States: EMPTY (no valid entry), ONE (head valid), TWO (head and skid valid).
- Accept = in_valid & in_ready at the falling edge. Issue = out_valid & out_ready at the falling edge.
- in_ready is a register output: 1 in EMPTY and ONE, 0 in TWO. It has no combinational path from out_ready.
- out_valid = head valid. out_data and out_dest always show the head register, which holds its last value when invalid.
- out_ctrl = head ctrl AND-masked by out_valid, so a bubble never asserts write or jump enables.
- EMPTY:
  - accept -> ONE, input loaded into head.
  - no accept -> stay EMPTY.
- ONE:
  - accept and issue -> ONE, head replaced by input.
  - accept only -> TWO, input loaded into skid.
  - issue only -> EMPTY.
  - neither -> stay ONE, head held.
- TWO:
  - issue -> ONE, skid moved to head, skid invalidated.
  - no issue -> stay TWO, both entries held.
  - No accept is possible in TWO.
- Latency: 1 falling edge from accept to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO; no entry is duplicated or lost except on flush.
- Flush has highest priority: at the falling edge with flush=1, head and skid valid bits clear and the state becomes EMPTY.
  - A same-edge accept is discarded; upstream treats it as consumed.
  - A same-edge issue still counts for downstream, since it sampled out_valid before the edge.
  - in_ready=1 at the next edge.
- Reset (async, any time including mid-transfer): state EMPTY, in_ready=0 while rst=1, then 1 from the first falling edge after release.
  - out_valid=0, out_ctrl=0, out_data=0, out_dest=0.
  - Skid contents are cleared to 0.
- in_valid=0 with arbitrary in_* values never changes state or data.

Optional Feature:
- Macro SEG_PIPE_STATS_EN.
- Defined: adds two output ports.
  - stall_cnt (32): counts falling edges where out_valid=1 and out_ready=0.
  - bubble_cnt (32): counts edges where out_valid=0 and out_ready=1.
  - Both saturate at 0xFFFFFFFF, clear on rst, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 edges with in_dest=1,2,3,4 -> out_dest 1,2,3,4 on consecutive edges, in_ready stays 1, out_valid drops to 0 one edge after in_valid drops.
- Backpressure: head holds dest=5, out_ready=0, send dest=6 -> state TWO, in_ready=0. Raise out_ready -> dest 5 then 6 issue in order with no drop and no duplicate.
- Bubble: idle with in_ctrl previously 0x3FFF -> out_valid=0 and out_ctrl=0x0000, while out_data keeps the last loaded value.
- Flush: in TWO with in_valid=1, assert flush for one edge -> out_valid=0, in_ready=1, out_ctrl=0. The next accepted entry (dest=9) appears alone.
- Async reset: assert rst mid-cycle while in ONE -> out_valid, out_ctrl, out_data and out_dest read 0 immediately, before any clock edge; after release, the first accepted entry appears 1 edge later.
- Stats (SEG_PIPE_STATS_EN): hold out_valid=1 with out_ready=0 for 3 edges -> stall_cnt=3. Force stall_cnt to 0xFFFFFFFF and stall once more -> it stays 0xFFFFFFFF.

Source files
------------

// File: rtl/segment_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : segment_pipe_reg
// Purpose  : Pipeline segment register with valid/ready, 2-entry skid buffer,
//            flush and bubble masking. Optional counters: SEG_PIPE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module segment_pipe_reg #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 192,
  parameter int LANES  = 8,
  parameter int DEST_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [DEST_W-1:0]         in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [DEST_W-1:0]         out_dest
`ifdef SEG_PIPE_STATS_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  localparam int c_data_w = LANES * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_in_ready;
  logic [CTRL_W-1:0]     r_head_ctrl;
  logic [c_data_w-1:0]   r_head_data;
  logic [DEST_W-1:0]     r_head_dest;
  logic [CTRL_W-1:0]     r_skid_ctrl;
  logic [c_data_w-1:0]   r_skid_data;
  logic [DEST_W-1:0]     r_skid_dest;

  logic                  w_head_valid;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_load_head_in;
  logic                  w_load_skid_in;
  logic                  w_head_from_skid;

  assign w_head_valid = (r_state != S_EMPTY);
  assign w_accept     = in_valid & r_in_ready;
  assign w_issue      = w_head_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_skid_in   = 1'b0;
    w_head_from_skid = 1'b0;
    if (flush) begin
      // Same-edge accept is dropped; upstream already considers it consumed.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = S_ONE;
            w_load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_issue) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt    = S_TWO;
            w_load_skid_in = 1'b1;
          end else if (w_issue) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_issue) begin
            w_state_nxt      = S_ONE;
            w_head_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // in_ready is registered so out_ready never reaches upstream combinationally.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_head_ctrl <= '0;
      r_head_data <= '0;
      r_head_dest <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_dest <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head_ctrl <= in_ctrl;
        r_head_data <= in_data;
        r_head_dest <= in_dest;
      end else if (w_head_from_skid) begin
        r_head_ctrl <= r_skid_ctrl;
        r_head_data <= r_skid_data;
        r_head_dest <= r_skid_dest;
      end
      if (w_load_skid_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
        r_skid_dest <= in_dest;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_head_valid;
  // Bubbles must never assert write or jump enables downstream.
  assign out_ctrl  = r_head_ctrl & {CTRL_W{w_head_valid}};
  assign out_data  = r_head_data;
  assign out_dest  = r_head_dest;

`ifdef SEG_PIPE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_head_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!w_head_valid && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_segment_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_pipe_reg
// Purpose  : Self-checking bench for segment_pipe_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_pipe_reg;
  localparam int CTRL_W = 14;
  localparam int DATA_W = 192;
  localparam int LANES  = 8;
  localparam int DEST_W = 4;
  localparam int DW     = LANES * DATA_W;
  localparam int NW     = DW / 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DW-1:0]     in_data = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [DEST_W-1:0] out_dest;
`ifdef SEG_PIPE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  segment_pipe_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES), .DEST_W(DEST_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_dest(out_dest)
`ifdef SEG_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [DEST_W-1:0] dest;
  } ent_t;

  // Reference: a FIFO of capacity two plus the last value seen at its front.
  ent_t              q[$];
  bit                m_rdy;
  logic [DW-1:0]     m_data;
  logic [DEST_W-1:0] m_dest;
  logic [31:0]       m_stall;
  logic [31:0]       m_bubble;
  int                checks = 0;
  int                errors = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic int diff_word(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < NW; i++) if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return 0;
  endfunction

  function automatic logic [CTRL_W-1:0] exp_ctrl();
    return (q.size() > 0) ? q[0].ctrl : '0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0; m_data = '0; m_dest = '0; m_stall = '0; m_bubble = '0;
  endtask

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                       input logic [DEST_W-1:0] t, input bit rdy, input bit fl);
    in_valid = v; in_ctrl = c; in_data = d; in_dest = t; out_ready = rdy; flush = fl;
  endtask

  // Advance one falling edge, update the model, return mid-high-phase.
  task automatic edge_step();
    ent_t e;
    bit   acc, iss;
    @(negedge clk);
    acc = in_valid && m_rdy;
    iss = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
    if ((q.size() == 0) && out_ready && (m_bubble != 32'hFFFF_FFFF)) m_bubble = m_bubble + 1;
    if (flush) begin
      q.delete();
    end else begin
      if (iss) void'(q.pop_front());
      if (acc) begin
        e.ctrl = in_ctrl; e.data = in_data; e.dest = in_dest;
        q.push_back(e);
      end
    end
    m_rdy = (q.size() < 2);
    if (q.size() > 0) begin m_data = q[0].data; m_dest = q[0].dest; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    model_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_data word %0d got %h exp 0", diff_word(out_data, '0), out_data[diff_word(out_data, '0)*32 +: 32]); end
    if (out_dest !== '0) begin errors++; $display("FAIL reset_dest got %h exp 0", out_dest); end
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready got %b exp 0", in_ready); end
    drive(0, '0, '0, '0, 0, 0);
    edge_step();
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 4; i++) begin
      drive(1, CTRL_W'($urandom()), rand_data(), DEST_W'(i), 1, 0);
      edge_step();
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      if (out_dest !== DEST_W'(i)) begin errors++; $display("FAIL stream_dest[%0d] got %0d exp %0d", i, out_dest, i); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      if (out_data !== m_data) begin errors++; $display("FAIL stream_data[%0d] word %0d got %h exp %h", i, diff_word(out_data, m_data), out_data[diff_word(out_data, m_data)*32 +: 32], m_data[diff_word(out_data, m_data)*32 +: 32]); end
    end
    drive(0, CTRL_W'($urandom()), rand_data(), DEST_W'($urandom()), 1, 0);
    edge_step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd5, 0, 0);
    edge_step();
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd6, 0, 0);
    edge_step();
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got %b exp 1", out_valid); end
    if (out_dest !== 4'd5) begin errors++; $display("FAIL bp_full_dest got %0d exp 5", out_dest); end
    drive(0, '0, '0, '0, 1, 0);
    edge_step();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", out_valid); end
    if (out_dest !== 4'd6) begin errors++; $display("FAIL bp_second_dest got %0d exp 6", out_dest); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_in_ready got %b exp 1", in_ready); end
    edge_step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] d;
    d = rand_data();
    drive(1, 14'h3FFF, d, 4'd3, 1, 0);
    edge_step();
    checks++;
    if (out_ctrl !== 14'h3FFF) begin errors++; $display("FAIL bubble_loaded_ctrl got %h exp 3fff", out_ctrl); end
    drive(0, CTRL_W'($urandom()), rand_data(), DEST_W'($urandom()), 1, 0);
    edge_step();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", out_valid); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL bubble_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== d) begin errors++; $display("FAIL bubble_data word %0d got %h exp %h", diff_word(out_data, d), out_data[diff_word(out_data, d)*32 +: 32], d[diff_word(out_data, d)*32 +: 32]); end
    if (out_dest !== 4'd3) begin errors++; $display("FAIL bubble_dest got %0d exp 3", out_dest); end
  endtask

  task automatic test_flush();
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd7, 0, 0);
    edge_step();
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd8, 0, 0);
    edge_step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_in_ready got %b exp 0", in_ready); end
    drive(1, 14'h3FFF, rand_data(), 4'd10, 0, 1);
    edge_step();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got %h exp 0", out_ctrl); end
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd9, 1, 0);
    edge_step();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid got %b exp 1", out_valid); end
    if (out_dest !== 4'd9) begin errors++; $display("FAIL post_flush_dest got %0d exp 9", out_dest); end
    drive(0, '0, '0, '0, 1, 0);
    edge_step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_flush_alone got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1, 14'h3FFF, rand_data(), 4'd11, 0, 0);
    edge_step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid); end
    if (out_ctrl !== '0) begin errors++; $display("FAIL areset_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== '0) begin errors++; $display("FAIL areset_data word %0d got %h exp 0", diff_word(out_data, '0), out_data[diff_word(out_data, '0)*32 +: 32]); end
    if (out_dest !== '0) begin errors++; $display("FAIL areset_dest got %0d exp 0", out_dest); end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd12, 1, 0);
    edge_step();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_first_edge_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_first_edge_in_ready got %b exp 1", in_ready); end
    edge_step();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_accept_valid got %b exp 1", out_valid); end
    if (out_dest !== 4'd12) begin errors++; $display("FAIL areset_accept_dest got %0d exp 12", out_dest); end
    drive(0, '0, '0, '0, 1, 0);
    edge_step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, CTRL_W'($urandom()), rand_data(), DEST_W'($urandom()),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      edge_step();
      checks += 5;
      if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, out_valid, q.size() > 0); end
      if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, in_ready, m_rdy); end
      if (out_ctrl !== exp_ctrl()) begin errors++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", n, out_ctrl, exp_ctrl()); end
      if (out_dest !== m_dest) begin errors++; $display("FAIL rnd_dest[%0d] got %0d exp %0d", n, out_dest, m_dest); end
      if (out_data !== m_data) begin errors++; $display("FAIL rnd_data[%0d] word %0d got %h exp %h", n, diff_word(out_data, m_data), out_data[diff_word(out_data, m_data)*32 +: 32], m_data[diff_word(out_data, m_data)*32 +: 32]); end
    end
    drive(0, '0, '0, '0, 1, 0);
    repeat (3) edge_step();
  endtask

`ifdef SEG_PIPE_STATS_EN
  task automatic test_stats();
    checks += 2;
    if (stall_cnt !== m_stall) begin errors++; $display("FAIL stats_rnd_stall got %0d exp %0d", stall_cnt, m_stall); end
    if (bubble_cnt !== m_bubble) begin errors++; $display("FAIL stats_rnd_bubble got %0d exp %0d", bubble_cnt, m_bubble); end
    rst = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    edge_step();
    drive(1, CTRL_W'($urandom()), rand_data(), 4'd13, 0, 0);
    edge_step();
    drive(0, '0, '0, '0, 0, 0);
    repeat (3) edge_step();
    checks += 2;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stats_stall3 got %0d exp 3", stall_cnt); end
    if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL stats_bubble0 got %0d exp 0", bubble_cnt); end
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_stall = 32'hFFFF_FFFF;
    edge_step();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_saturate got %h exp ffffffff", stall_cnt); end
    drive(0, '0, '0, '0, 1, 1);
    repeat (2) edge_step();
    checks++;
    if (bubble_cnt !== m_bubble) begin errors++; $display("FAIL stats_bubble got %0d exp %0d", bubble_cnt, m_bubble); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
`ifdef SEG_PIPE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
